vscale_irq_csr_unit: RTL and testbench
======================================

VSCALE_IRQ_CSR_UNIT -- requirements
Module: vscale_irq_csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: CSR data width (32 or 64).
REQ-002 SHALL have parameter NUM_IRQ, default 8: external interrupt sources (1..16).
REQ-003 SHALL have parameter EDGE_MASK, default all-zero: per-source mode, bit i=1 means edge-triggered, 0 means level.
REQ-004 SHALL have parameter VEC_EN, default 1: vectored trap mode permitted.
REQ-005 SHALL have parameter RESET_VEC, default 'h100: mtvec reset value.
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- csr_addr  in  12  CSR address.
- csr_cmd  in  3  100 read, 101 write, 110 set, 111 clear, 0xx idle.
- csr_wdata  in  XLEN  write operand.
- csr_rdata  out  XLEN  combinational read data.
- csr_illegal  out  1  combinational access fault.
- irq_in  in  NUM_IRQ  asynchronous interrupt lines.
- cur_pc  in  XLEN  PC of the oldest unretired instruction.
- exception  in  1  synchronous exception this cycle.
- exception_code  in  4  exception cause.
- eret  in  1  return-from-trap.
- trap_valid  out  1  trap redirect request.
- trap_ready  in  1  core accepts redirect.
- trap_pc  out  XLEN  redirect target.
- epc  out  XLEN  mepc value, used on eret.

Function
REQ-007 SHALL support these CSRs; all others are undefined:
- mstatus 0x300: bit0 IE, bit1 PIE.
- mie 0x304: NUM_IRQ bits.
- mtvec 0x305: bit0 MODE, low 2 bits of the base read zero.
- mepc 0x341: bits[1:0] forced 0.
- mcause 0x342: MSB is the interrupt flag, [3:0] is the code.
- mip 0x344.
REQ-008 SHALL compute write data as wdata for write, rdata|wdata for set, and rdata&~wdata for clear.
REQ-009 SHALL assert csr_illegal when csr_cmd[2]=1 and either:
- the address is undefined; or
- the command is write or set to mip.
An illegal access SHALL modify no state.
REQ-010 SHALL synchronise each irq_in bit through two flops; a raw change reaches mip after 2 clk edges for level sources and 3 for edge sources.
REQ-011 Level source: mip bit SHALL equal the synchronised input.
REQ-012 Edge source: mip bit SHALL set on a synchronised 0->1 transition and clear by CSR clear or by taking that interrupt; if set and clear coincide, set wins.
REQ-013 SHALL form pend = mip & mie; the selected interrupt is the lowest index set in pend.
REQ-014 SHALL assert trap_valid, registered, on either of these conditions:
- exception; or
- IE=1 and pend!=0.
trap_valid SHALL hold until trap_ready and keep its cause fixed while held.
REQ-015 Exceptions SHALL take priority over interrupts; an exception arriving while an interrupt trap is pending but not accepted SHALL replace it.
REQ-016 Trap target SHALL be:
- exceptions: the mtvec base;
- interrupts with MODE=1 and VEC_EN=1: base + 4*index;
- otherwise: the base.
REQ-017 On the cycle of trap_valid&&trap_ready, the unit SHALL do all of the following:
- mepc<=cur_pc;
- mcause<={interrupt flag, code or index};
- PIE<=IE and IE<=0;
- clear the taken edge-pending bit.
REQ-018 On eret, the unit SHALL set IE<=PIE and PIE<=1; eret coinciding with a trap acceptance SHALL be ignored.
REQ-019 Trap acceptance SHALL override a same-cycle CSR write to mstatus, mepc or mcause; writes to other CSRs SHALL proceed.
REQ-020 MODE SHALL be read-only 0 when VEC_EN=0.
REQ-021 epc SHALL always equal mepc.

Reset
REQ-022 On reset:
- mstatus, mie, mepc, mcause, mip, synchronisers, trap_valid <= 0;
- mtvec <= RESET_VEC with MODE=0.
REQ-023 Reset mid-trap SHALL drop the pending trap_valid with no CSR side effects.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Scenario 1: write mie=0x05, mstatus=0x1, raise irq_in[2] (level) -> trap_valid 3 cycles later; with mtvec=0x101, trap_pc=0x108 and mcause=0x80000002.
- Scenario 2: irq_in[0] and irq_in[2] pending with exception code 2 in the same cycle -> exception taken first, mcause=0x2, trap_pc=0x100; after eret, the index-0 interrupt is taken.
- Scenario 3: edge source 1 pulses for one cycle with IE=0 -> mip[1] stays 1; CSR clear 0x2 on mip clears it; a write to mip gives csr_illegal=1 and mip unchanged.
- Scenario 4: trap_ready held low for 5 cycles -> trap_valid and trap_pc stable; on acceptance mepc=cur_pc&~3 and IE=0, PIE=1.
- Scenario 5: read 0x7C0 -> csr_illegal=1, rdata=0; reset asserted during a pending trap -> trap_valid=0 next cycle and mtvec=RESET_VEC.

Source files
------------

// File: rtl/vscale_irq_csr_unit.sv
// Machine-mode trap CSRs and interrupt controller: CSR access, irq sync/pending, trap request and eret.
// CSR read is combinational; trap_valid is registered and held with a fixed cause until trap_ready.
module vscale_irq_csr_unit #(
  parameter int                 XLEN      = 32,
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter bit                 VEC_EN    = 1'b1,
  parameter logic [XLEN-1:0]    RESET_VEC = 'h100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [2:0]         csr_cmd,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [XLEN-1:0]    cur_pc,
  input  logic               exception,
  input  logic [3:0]         exception_code,
  input  logic               eret,
  output logic               trap_valid,
  input  logic               trap_ready,
  output logic [XLEN-1:0]    trap_pc,
  output logic [XLEN-1:0]    epc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic               ie, pie;
  logic [NUM_IRQ-1:0] mie;
  logic [XLEN-3:0]    mtvec_base;
  logic               mtvec_mode;
  logic [XLEN-3:0]    mepc;
  logic               mcause_int;
  logic [3:0]         mcause_code;
  logic [NUM_IRQ-1:0] sync1, sync2, sync_prev, mip_edge, mip_edge_next, mip, pend;
  logic               trap_int;
  logic [3:0]         trap_code;
  logic [3:0]         sel_idx;
  logic               addr_known, mip_wr, csr_we, accept;
  logic [XLEN-1:0]    csr_new, irq_target;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^cur_pc[1:0];

  assign mip  = (sync2 & ~EDGE_MASK) | (mip_edge & EDGE_MASK);
  assign pend = mip & mie;
  assign epc  = {mepc, 2'b00};
  assign accept = trap_valid && trap_ready;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = 4'(i);
    end
  end

  assign irq_target = mtvec_mode ? {mtvec_base + (XLEN-2)'(sel_idx), 2'b00}
                                 : {mtvec_base, 2'b00};

  always_comb begin
    addr_known = 1'b1;
    csr_rdata  = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = XLEN'({pie, ie});
      ADDR_MIE:     csr_rdata = XLEN'(mie);
      ADDR_MTVEC:   csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
      ADDR_MEPC:    csr_rdata = {mepc, 2'b00};
      ADDR_MCAUSE: begin
        csr_rdata[XLEN-1] = mcause_int;
        csr_rdata[3:0]    = mcause_code;
      end
      ADDR_MIP:     csr_rdata = XLEN'(mip);
      default:      addr_known = 1'b0;
    endcase
  end

  // mip is only clearable from software; write and set are faults
  assign mip_wr      = (csr_addr == ADDR_MIP) && (csr_cmd[1:0] == 2'b01 || csr_cmd[1:0] == 2'b10);
  assign csr_illegal = csr_cmd[2] && (!addr_known || mip_wr);
  assign csr_we      = csr_cmd[2] && (csr_cmd[1:0] != 2'b00) && !csr_illegal;

  always_comb begin
    case (csr_cmd[1:0])
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  // Clears are applied before the rising-edge set so a coincident new edge survives
  always_comb begin
    mip_edge_next = mip_edge;
    if (csr_we && csr_addr == ADDR_MIP) mip_edge_next = mip_edge & csr_new[NUM_IRQ-1:0];
    if (accept && trap_int) mip_edge_next = mip_edge_next & ~(NUM_IRQ'(1) << trap_code);
    mip_edge_next = (mip_edge_next | (sync2 & ~sync_prev)) & EDGE_MASK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie          <= 1'b0;
      pie         <= 1'b0;
      mie         <= '0;
      mtvec_base  <= RESET_VEC[XLEN-1:2];
      mtvec_mode  <= 1'b0;
      mepc        <= '0;
      mcause_int  <= 1'b0;
      mcause_code <= '0;
      sync1       <= '0;
      sync2       <= '0;
      sync_prev   <= '0;
      mip_edge    <= '0;
      trap_valid  <= 1'b0;
      trap_int    <= 1'b0;
      trap_code   <= '0;
      trap_pc     <= '0;
    end else begin
      sync1     <= irq_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      mip_edge  <= mip_edge_next;

      if (csr_we) begin
        case (csr_addr)
          ADDR_MIE: mie <= csr_new[NUM_IRQ-1:0];
          ADDR_MTVEC: begin
            mtvec_base <= csr_new[XLEN-1:2];
            mtvec_mode <= VEC_EN ? csr_new[0] : 1'b0;
          end
          default: ;
        endcase
      end

      if (csr_we && !accept) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            ie  <= csr_new[0];
            pie <= csr_new[1];
          end
          ADDR_MEPC: mepc <= csr_new[XLEN-1:2];
          ADDR_MCAUSE: begin
            mcause_int  <= csr_new[XLEN-1];
            mcause_code <= csr_new[3:0];
          end
          default: ;
        endcase
      end

      if (eret && !accept) begin
        ie  <= pie;
        pie <= 1'b1;
      end

      if (accept) begin
        mepc        <= cur_pc[XLEN-1:2];
        mcause_int  <= trap_int;
        mcause_code <= trap_code;
        pie         <= ie;
        ie          <= 1'b0;
      end

      // An exception may displace a held interrupt request, never the reverse
      if (accept) begin
        trap_valid <= 1'b0;
      end else if (exception && (!trap_valid || trap_int)) begin
        trap_valid <= 1'b1;
        trap_int   <= 1'b0;
        trap_code  <= exception_code;
        trap_pc    <= {mtvec_base, 2'b00};
      end else if (!trap_valid && ie && (pend != '0)) begin
        trap_valid <= 1'b1;
        trap_int   <= 1'b1;
        trap_code  <= sel_idx;
        trap_pc    <= irq_target;
      end
    end
  end

endmodule

// File: tb/tb_vscale_irq_csr_unit.sv
// Directed bench for vscale_irq_csr_unit: source 1 is edge-triggered, all others level.
module tb_vscale_irq_csr_unit;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MIE     = 12'h304;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MIP     = 12'h344;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [7:0]  irq_in;
  logic [31:0] cur_pc;
  logic        exception;
  logic [3:0]  exception_code;
  logic        eret;
  logic        trap_valid;
  logic        trap_ready;
  logic [31:0] trap_pc;
  logic [31:0] epc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] v;

  vscale_irq_csr_unit #(.XLEN(32), .NUM_IRQ(8), .EDGE_MASK(8'h02), .VEC_EN(1'b1), .RESET_VEC(32'h100)) dut (
    .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_cmd(csr_cmd), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .irq_in(irq_in), .cur_pc(cur_pc),
    .exception(exception), .exception_code(exception_code), .eret(eret), .trap_valid(trap_valid),
    .trap_ready(trap_ready), .trap_pc(trap_pc), .epc(epc)
  );

  always #10 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_csr(input logic [2:0] cmd, input logic [11:0] a, input logic [31:0] d);
    csr_cmd = cmd; csr_addr = a; csr_wdata = d;
    tick;
    csr_cmd = 3'b000;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] val);
    csr_cmd = 3'b100; csr_addr = a;
    #1;
    val = csr_rdata;
    csr_cmd = 3'b000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL rst_trap_valid got %h want 0", trap_valid); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc got %h want 0", epc); end
    rd(MTVEC, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL rst_mtvec got %h want 100", v); end
    rd(MSTATUS, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h want 0", v); end
    rd(MCAUSE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h want 0", v); end
    tick;
  endtask

  task automatic test_level_irq;
    do_csr(3'b101, MIE, 32'h05);
    do_csr(3'b110, MIE, 32'h10);
    rd(MIE, v);
    checks++; if (v !== 32'h15) begin errors++; $display("FAIL mie_set got %h want 15", v); end
    do_csr(3'b111, MIE, 32'h10);
    rd(MIE, v);
    checks++; if (v !== 32'h05) begin errors++; $display("FAIL mie_clear got %h want 05", v); end
    do_csr(3'b101, MSTATUS, 32'h1);
    do_csr(3'b101, MTVEC, 32'h101);
    irq_in = 8'h04;
    tick; tick;
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL lvl_early_valid got %h want 0", trap_valid); end
    rd(MIP, v);
    checks++; if (v !== 32'h04) begin errors++; $display("FAIL lvl_mip got %h want 04", v); end
    tick;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL lvl_valid got %h want 1", trap_valid); end
    checks++; if (trap_pc !== 32'h108) begin errors++; $display("FAIL lvl_trap_pc got %h want 108", trap_pc); end
    cur_pc = 32'h2000_0010; trap_ready = 1'b1;
    tick;
    trap_ready = 1'b0;
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL lvl_valid_drop got %h want 0", trap_valid); end
    rd(MCAUSE, v);
    checks++; if (v !== 32'h8000_0002) begin errors++; $display("FAIL lvl_mcause got %h want 80000002", v); end
    checks++; if (epc !== 32'h2000_0010) begin errors++; $display("FAIL lvl_epc got %h want 20000010", epc); end
    rd(MSTATUS, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL lvl_mstatus got %h want 2", v); end
    irq_in = 8'h00;
    tick; tick;
    rd(MIP, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL lvl_mip_low got %h want 0", v); end
  endtask

  task automatic test_priority;
    do_csr(3'b101, MSTATUS, 32'h1);
    irq_in = 8'h05;
    tick; tick;
    exception = 1'b1; exception_code = 4'd2;
    tick;
    exception = 1'b0;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL pri_valid got %h want 1", trap_valid); end
    checks++; if (trap_pc !== 32'h100) begin errors++; $display("FAIL pri_exc_pc got %h want 100", trap_pc); end
    cur_pc = 32'h3000; trap_ready = 1'b1;
    tick;
    trap_ready = 1'b0;
    rd(MCAUSE, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL pri_exc_mcause got %h want 2", v); end
    checks++; if (epc !== 32'h3000) begin errors++; $display("FAIL pri_epc got %h want 3000", epc); end
    eret = 1'b1;
    tick;
    eret = 1'b0;
    rd(MSTATUS, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL pri_eret_mstatus got %h want 3", v); end
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL pri_eret_valid got %h want 0", trap_valid); end
    tick;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL pri_irq_valid got %h want 1", trap_valid); end
    checks++; if (trap_pc !== 32'h100) begin errors++; $display("FAIL pri_irq_pc got %h want 100", trap_pc); end
    trap_ready = 1'b1;
    tick;
    trap_ready = 1'b0;
    rd(MCAUSE, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL pri_irq_mcause got %h want 80000000", v); end
    irq_in = 8'h00;
    tick; tick;
  endtask

  task automatic test_edge_irq;
    irq_in = 8'h02;
    tick;
    irq_in = 8'h00;
    tick;
    rd(MIP, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_mip_early got %h want 0", v); end
    tick;
    rd(MIP, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL edge_mip_set got %h want 2", v); end
    tick; tick; tick;
    rd(MIP, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL edge_mip_sticky got %h want 2", v); end
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL edge_no_trap got %h want 0", trap_valid); end
    csr_cmd = 3'b101; csr_addr = MIP; csr_wdata = 32'h0;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL mip_write_illegal got %h want 1", csr_illegal); end
    tick;
    csr_cmd = 3'b110; csr_wdata = 32'h0;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL mip_set_illegal got %h want 1", csr_illegal); end
    csr_cmd = 3'b000;
    rd(MIP, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL mip_after_write got %h want 2", v); end
    csr_cmd = 3'b111; csr_addr = MIP; csr_wdata = 32'h2;
    #1;
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL mip_clear_legal got %h want 0", csr_illegal); end
    tick;
    csr_cmd = 3'b000;
    rd(MIP, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mip_cleared got %h want 0", v); end
  endtask

  task automatic test_hold;
    do_csr(3'b101, MSTATUS, 32'h1);
    irq_in = 8'h04;
    tick; tick; tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %h want 1", i, trap_valid); end
      checks++; if (trap_pc !== 32'h108) begin errors++; $display("FAIL hold_pc[%0d] got %h want 108", i, trap_pc); end
      tick;
    end
    cur_pc = 32'h4007; trap_ready = 1'b1;
    csr_cmd = 3'b101; csr_addr = MSTATUS; csr_wdata = 32'h1;
    tick;
    trap_ready = 1'b0; csr_cmd = 3'b000;
    checks++; if (epc !== 32'h4004) begin errors++; $display("FAIL hold_epc got %h want 4004", epc); end
    rd(MSTATUS, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL hold_mstatus got %h want 2", v); end
    rd(MCAUSE, v);
    checks++; if (v !== 32'h8000_0002) begin errors++; $display("FAIL hold_mcause got %h want 80000002", v); end
    irq_in = 8'h00;
    tick; tick;
  endtask

  task automatic test_exc_replace;
    do_csr(3'b101, MSTATUS, 32'h1);
    irq_in = 8'h04;
    tick; tick; tick;
    checks++; if (trap_pc !== 32'h108) begin errors++; $display("FAIL repl_irq_pc got %h want 108", trap_pc); end
    exception = 1'b1; exception_code = 4'd5;
    tick;
    exception = 1'b0;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL repl_valid got %h want 1", trap_valid); end
    checks++; if (trap_pc !== 32'h100) begin errors++; $display("FAIL repl_pc got %h want 100", trap_pc); end
    trap_ready = 1'b1;
    tick;
    trap_ready = 1'b0;
    rd(MCAUSE, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL repl_mcause got %h want 5", v); end
    irq_in = 8'h00;
    tick; tick;
  endtask

  task automatic test_illegal_reset;
    csr_cmd = 3'b100; csr_addr = 12'h7C0;
    #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL undef_illegal got %h want 1", csr_illegal); end
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL undef_rdata got %h want 0", csr_rdata); end
    csr_cmd = 3'b000;
    do_csr(3'b101, MTVEC, 32'h203);
    rd(MTVEC, v);
    checks++; if (v !== 32'h201) begin errors++; $display("FAIL mtvec_mask got %h want 201", v); end
    do_csr(3'b101, MSTATUS, 32'h1);
    irq_in = 8'h04;
    tick; tick; tick;
    checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL rst_pend_valid got %h want 1", trap_valid); end
    checks++; if (trap_pc !== 32'h208) begin errors++; $display("FAIL rst_pend_pc got %h want 208", trap_pc); end
    reset = 1'b1;
    tick;
    checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %h want 0", trap_valid); end
    rd(MTVEC, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL rst_mid_mtvec got %h want 100", v); end
    rd(MSTATUS, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_mstatus got %h want 0", v); end
    reset = 1'b0; irq_in = 8'h00;
    tick;
  endtask

  initial begin
    reset = 1'b1; csr_addr = '0; csr_cmd = 3'b000; csr_wdata = '0; irq_in = '0;
    cur_pc = '0; exception = 1'b0; exception_code = '0; eret = 1'b0; trap_ready = 1'b0;
    test_reset;
    test_level_irq;
    test_priority;
    test_edge_irq;
    test_hold;
    test_exc_replace;
    test_illegal_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
